// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and MEM/WB bundle type for the MIPS pipeline
// Purpose: writeback-source and load-size encodings plus the MEM/WB control bundle.
// Ports: none (package).
package mips_pkg;

  // Writeback source select; 2'b11 is decoded as ALU by consumers.
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  // Load size; 2'b11 is decoded as a full word by consumers.
  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  // Width-independent control part of the MEM/WB register. The data fields
  // depend on DATA_W and live beside it in the stage itself.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] load_size;
    logic       load_unsigned;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational sub-word load alignment and extension
// Purpose: pick the byte/half lane of a raw memory word and sign/zero extend it.
// Ports:
//   i_data     raw word read from data memory
//   i_size     load size (LOAD_BYTE / LOAD_HALF / word)
//   i_unsigned 1 = zero-extend, 0 = sign-extend
//   i_offset   address low bits selecting the lane
//   o_data     aligned, extended value
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [DATA_W-1:0] o_data
);

  logic [OFF_W-1:0]  half_off;
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              byte_sign;
  logic              half_sign;

  always_comb begin
    // Misaligned halves are silently aligned down by dropping offset bit 0.
    half_off   = {i_offset[OFF_W-1:1], 1'b0};
    byte_shift = i_data >> {i_offset, 3'b000};
    half_shift = i_data >> {half_off, 3'b000};
    byte_v     = byte_shift[7:0];
    half_v     = half_shift[15:0];
    byte_sign  = ~i_unsigned & byte_v[7];
    half_sign  = ~i_unsigned & half_v[15];
    case (i_size)
      LOAD_BYTE: o_data = {{(DATA_W-8){byte_sign}}, byte_v};
      LOAD_HALF: o_data = {{(DATA_W-16){half_sign}}, half_v};
      default:   o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register and writeback stage
// Purpose: latch MEM-stage results (with stall/flush), select the writeback
// source and align sub-word loads after the register.
// Optional feature: define MEM_WB_RETIRE_CNT_EN for the retired-instruction counter.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   i_valid/i_stall/i_flush       pipeline control (flush beats stall)
//   i_alu_result/i_read_data/i_pc_plus_4  candidate writeback values
//   i_write_register/i_reg_write  destination and its write enable
//   i_wb_sel/i_load_size/i_load_unsigned/i_byte_offset  writeback/load control
//   o_write_data/o_write_register/o_reg_write/o_valid   register-file port
//   o_retired_count/i_count_clear retire counter (tied off without the macro)
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int OFF_W      = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [DATA_W-1:0]     i_alu_result,
  input  logic [DATA_W-1:0]     i_read_data,
  input  logic [DATA_W-1:0]     i_pc_plus_4,
  input  logic [REG_ADDR_W-1:0] i_write_register,
  input  logic                  i_reg_write,
  input  logic [1:0]            i_wb_sel,
  input  logic [1:0]            i_load_size,
  input  logic                  i_load_unsigned,
  input  logic [OFF_W-1:0]      i_byte_offset,
  output logic [DATA_W-1:0]     o_write_data,
  output logic [REG_ADDR_W-1:0] o_write_register,
  output logic                  o_reg_write,
  output logic                  o_valid,
  output logic [CNT_W-1:0]      o_retired_count,
  input  logic                  i_count_clear
);

  mem_wb_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     pc4_q, pc4_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [DATA_W-1:0]     load_data;

  always_comb begin
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    off_d   = off_q;
    if (i_flush) begin
      // Only valid/reg_write matter for a bubble; the rest is cleared for tidiness.
      ctrl_d  = '0;
      alu_d   = '0;
      rdata_d = '0;
      pc4_d   = '0;
      rd_d    = '0;
      off_d   = '0;
    end else if (!i_stall) begin
      ctrl_d.valid         = i_valid;
      ctrl_d.reg_write     = i_reg_write;
      ctrl_d.wb_sel        = i_wb_sel;
      ctrl_d.load_size     = i_load_size;
      ctrl_d.load_unsigned = i_load_unsigned;
      alu_d                = i_alu_result;
      rdata_d              = i_read_data;
      pc4_d                = i_pc_plus_4;
      rd_d                 = i_write_register;
      off_d                = i_byte_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      off_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
      off_q   <= off_d;
    end
  end

  // Raw read data is stored; alignment happens on the registered copy.
  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .i_data     (rdata_q),
    .i_size     (ctrl_q.load_size),
    .i_unsigned (ctrl_q.load_unsigned),
    .i_offset   (off_q),
    .o_data     (load_data)
  );

  always_comb begin
    case (ctrl_q.wb_sel)
      WB_SEL_MEM:  o_write_data = load_data;
      WB_SEL_LINK: o_write_data = pc4_q;
      default:     o_write_data = alu_q;
    endcase
  end

  assign o_write_register = rd_q;
  assign o_valid          = ctrl_q.valid;
  // $0 is hard-wired zero, so writes to it are always dropped.
  assign o_reg_write      = ctrl_q.reg_write & ctrl_q.valid & (|rd_q);

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_count_clear) begin
      cnt_d = '0;
    end else if (i_valid && !i_stall && !i_flush) begin
      cnt_d = cnt_q + 1'b1;  // wraps naturally at 2^CNT_W
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_retired_count = cnt_q;
`else
  logic unused_count_clear;
  assign unused_count_clear = i_count_clear;
  assign o_retired_count    = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - directed self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid, i_stall, i_flush;
  logic [31:0]       i_alu_result, i_read_data, i_pc_plus_4;
  logic [RA_W-1:0]   i_write_register;
  logic              i_reg_write;
  logic [1:0]        i_wb_sel, i_load_size;
  logic              i_load_unsigned;
  logic [1:0]        i_byte_offset;
  logic [31:0]       o_write_data;
  logic [RA_W-1:0]   o_write_register;
  logic              o_reg_write, o_valid;
  logic [CNT_W-1:0]  o_retired_count;
  logic              i_count_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (RA_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_valid          (i_valid),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_alu_result     (i_alu_result),
    .i_read_data      (i_read_data),
    .i_pc_plus_4      (i_pc_plus_4),
    .i_write_register (i_write_register),
    .i_reg_write      (i_reg_write),
    .i_wb_sel         (i_wb_sel),
    .i_load_size      (i_load_size),
    .i_load_unsigned  (i_load_unsigned),
    .i_byte_offset    (i_byte_offset),
    .o_write_data     (o_write_data),
    .o_write_register (o_write_register),
    .o_reg_write      (o_reg_write),
    .o_valid          (o_valid),
    .o_retired_count  (o_retired_count),
    .i_count_clear    (i_count_clear)
  );

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic [1:0] size,
                       input logic uns, input logic [1:0] off);
    i_valid = v; i_wb_sel = sel; i_alu_result = alu; i_read_data = rdata;
    i_pc_plus_4 = pc4; i_write_register = rd; i_reg_write = rw;
    i_load_size = size; i_load_unsigned = uns; i_byte_offset = off;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_stall = 0; i_flush = 0; i_count_clear = 0;
    drive(1, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd3, 1, 2'b10, 0, 0);
    step(); step();
    checks++; if (o_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", o_write_data); end
    checks++; if (o_write_register !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", o_write_register); end
    checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", o_reg_write); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_retired_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_retired_count); end
    // Valid instruction in flight, then reset mid-stream.
    reset = 1'b0;
    step();
    checks++; if (o_valid !== 1'b1 || o_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL inflight got v=%b d=%h exp v=1 d=deadbeef", o_valid, o_write_data); end
    reset = 1'b1;
    step();
    checks++; if ({o_valid, o_reg_write, o_write_register, o_write_data} !== '0) begin errors++; $display("FAIL midreset got v=%b rw=%b rd=%0d d=%h exp all 0", o_valid, o_reg_write, o_write_register, o_write_data); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    drive(1, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 5'd8, 1, 2'b00, 0, 2'd1);
    step();
    checks++; if (o_write_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata got %h exp 12345678", o_write_data); end
    checks++; if (o_write_register !== 5'd8) begin errors++; $display("FAIL alu_rd got %0d exp 8", o_write_register); end
    checks++; if (o_reg_write !== 1'b1) begin errors++; $display("FAIL alu_rw got %b exp 1", o_reg_write); end
    // wb_sel 11 falls back to the ALU value.
    drive(1, 2'b11, 32'hA5A5_0001, 32'h1111_1111, 32'h2222_2222, 5'd9, 1, 2'b00, 0, 0);
    step();
    checks++; if (o_write_data !== 32'hA5A5_0001) begin errors++; $display("FAIL sel11_wdata got %h exp a5a50001", o_write_data); end
    // Invalid instruction never writes.
    drive(0, 2'b00, 32'h1, 32'h0, 32'h0, 5'd9, 1, 2'b00, 0, 0);
    step();
    checks++; if (o_reg_write !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL invalid_rw got rw=%b v=%b exp 0 0", o_reg_write, o_valid); end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  task automatic test_loads();
    load_vec_t vec[7];
    vec[0] = '{2'b00, 1'b0, 2'd1, 32'h0000_007F};
    vec[1] = '{2'b00, 1'b0, 2'd3, 32'hFFFF_FF80};
    vec[2] = '{2'b00, 1'b1, 2'd3, 32'h0000_0080};
    vec[3] = '{2'b01, 1'b0, 2'd2, 32'hFFFF_80FF};
    vec[4] = '{2'b01, 1'b0, 2'd3, 32'hFFFF_80FF};
    vec[5] = '{2'b01, 1'b1, 2'd0, 32'h0000_7F01};
    vec[6] = '{2'b10, 1'b0, 2'd3, 32'h80FF_7F01};
    for (int i = 0; i < 7; i++) begin
      drive(1, 2'b01, 32'h5555_5555, 32'h80FF_7F01, 32'h0, 5'd5, 1,
            vec[i].size, vec[i].uns, vec[i].off);
      step();
      checks++;
      if (o_write_data !== vec[i].exp) begin
        errors++;
        $display("FAIL load_%0d got %h exp %h", i, o_write_data, vec[i].exp);
      end
    end
  endtask

  task automatic test_link();
    drive(1, 2'b10, 32'h0, 32'h0, 32'h0040_0008, 5'd31, 1, 2'b00, 0, 0);
    step();
    checks++; if (o_write_data !== 32'h0040_0008 || o_reg_write !== 1'b1) begin errors++; $display("FAIL link got d=%h rw=%b exp 00400008 1", o_write_data, o_reg_write); end
    drive(1, 2'b10, 32'h0, 32'h0, 32'h0040_0008, 5'd0, 1, 2'b00, 0, 0);
    step();
    checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL link_r0_rw got %b exp 0", o_reg_write); end
  endtask

  task automatic test_stall_flush();
    drive(1, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd12, 1, 2'b00, 0, 0);
    step();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 2'b10, 32'h0BAD_0BAD, 32'h1, 32'h7777_0000, 5'd20 + k[4:0], 1, 2'b00, 1, 2'd2);
      step();
      checks++;
      if (o_write_data !== 32'hCAFE_F00D || o_write_register !== 5'd12 ||
          o_reg_write !== 1'b1 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d got d=%h rd=%0d rw=%b v=%b exp cafef00d 12 1 1",
                 k, o_write_data, o_write_register, o_reg_write, o_valid);
      end
    end
    i_flush = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0) begin errors++; $display("FAIL stall_flush got v=%b rw=%b exp 0 0", o_valid, o_reg_write); end
    i_flush = 1'b0; i_stall = 1'b0;
  endtask

  task automatic test_counter();
`ifdef MEM_WB_RETIRE_CNT_EN
    drive(1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd1, 1, 2'b00, 0, 0);
    i_valid = 0; i_count_clear = 1; step(); i_count_clear = 0;
    checks++; if (o_retired_count !== 4'd0) begin errors++; $display("FAIL cnt_clear got %0d exp 0", o_retired_count); end
    // 5 captures, with one stalled and one flushed cycle interleaved.
    i_valid = 1;
    step(); step();
    i_stall = 1; step(); i_stall = 0;
    step();
    i_flush = 1; step(); i_flush = 0;
    step(); step();
    checks++; if (o_retired_count !== 4'd5) begin errors++; $display("FAIL cnt_five got %0d exp 5", o_retired_count); end
    i_valid = 0; i_count_clear = 1; step(); i_count_clear = 0;
    i_valid = 1;
    for (int k = 0; k < 15; k++) step();
    checks++; if (o_retired_count !== 4'd15) begin errors++; $display("FAIL cnt_max got %0d exp 15", o_retired_count); end
    step();
    checks++; if (o_retired_count !== 4'd0) begin errors++; $display("FAIL cnt_wrap got %0d exp 0", o_retired_count); end
    step(); step();
    i_count_clear = 1; step(); i_count_clear = 0;
    checks++; if (o_retired_count !== 4'd0) begin errors++; $display("FAIL cnt_clr_win got %0d exp 0", o_retired_count); end
    i_valid = 0;
`else
    drive(1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd1, 1, 2'b00, 0, 0);
    step(); step(); step();
    checks++; if (o_retired_count !== 4'd0) begin errors++; $display("FAIL cnt_tied got %0d exp 0", o_retired_count); end
    i_valid = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_stall_flush();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Parametrised MEM/WB pipeline register and writeback stage for the MIPS pipeline. It latches the memory-stage results and supports stall and flush. It selects the writeback source from ALU, load, or link (PC+4) and performs sub-word load alignment with sign/zero extension. It drives the register-file write port and the forwarding unit from registered state.

## Interface
- DATA_W, 32: datapath width; multiple of 8, ≥ 32.
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 32: retire-counter width (used only with MEM_WB_RETIRE_CNT_EN).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  MEM stage presents a real instruction.
- i_stall  in  1  hold the current WB contents.
- i_flush  in  1  load a bubble; takes priority over i_stall.
- i_alu_result  in  DATA_W  ALU result.
- i_read_data  in  DATA_W  raw word read from data memory.
- i_pc_plus_4  in  DATA_W  link value for JAL/JALR.
- i_write_register  in  REG_ADDR_W  destination register.
- i_reg_write  in  1  destination write enable.
- i_wb_sel  in  2  writeback source: 00 ALU, 01 MEM, 10 LINK, 11 treated as ALU.
- i_load_size  in  2  load size: 00 byte, 01 half, 10/11 full word.
- i_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- i_byte_offset  in  $clog2(DATA_W/8)  address low bits of the load.
- o_write_data  out  DATA_W  value written to the register file.
- o_write_register  out  REG_ADDR_W  destination register.
- o_reg_write  out  1  qualified write enable.
- o_valid  out  1  WB holds a real instruction.
- o_retired_count  out  CNT_W  retired-instruction count (macro only).
- i_count_clear  in  1  synchronous counter clear (macro only).

## Operation
- Register update per edge, in priority order:
  - reset: all fields go to 0.
  - i_flush: valid = 0 and reg_write = 0; other fields don't-care, but are cleared.
  - i_stall: hold all fields.
  - otherwise: capture all inputs.
- Data-path selection and alignment are combinational from the registered fields. Raw read data is stored and aligned after the register.
- Byte load: lane = offset × 8, extract 8 bits, then extend to DATA_W.
- Half load: lane = (offset with bit 0 forced to 0) × 8, extract 16 bits, then extend. A misaligned half load is silently aligned down; no exception is raised.
- Word load: the full DATA_W is passed through unchanged; offset is ignored.
- o_reg_write = reg_write & valid & (write_register ≠ 0). Writes to $0 are always suppressed.
- o_write_register and o_valid come straight from the register.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset value of every output is 0.
- o_write_data is combinational from the register; the datapath is not registered again.
- Flush and stall asserted together: flush wins.
- Stall held for K cycles: the outputs stay constant for K cycles. The register file may see repeated identical writes, which is harmless.

## Configuration
- MEM_WB_RETIRE_CNT_EN defined:
  - The counter increments on each edge where a valid instruction is captured (i_valid & ~i_stall & ~i_flush & ~reset).
  - It wraps from 2^CNT_W−1 to 0.
  - i_count_clear zeroes it and wins over increment.
  - Reset value is 0.
- Undefined: o_retired_count is tied to 0 and i_count_clear is ignored. The ports still exist so instantiations do not change.

## Structure
- The shared package mips_pkg holds:
  - the WB_SEL_ALU/MEM/LINK encodings;
  - the LOAD_BYTE/HALF/WORD encodings;
  - a typedef for the MEM/WB register bundle.
- One natural sub-module, load_align: purely combinational, taking data, size, unsigned and offset and producing the extended value.

## Test plan
- Reset mid-stream: with reset = 1 on any edge, all outputs are 0 on the next cycle, including a valid in-flight instruction.
- ALU path: wb_sel=00, alu=0x1234_5678, rd=8, reg_write=1 → one cycle later o_write_data=0x1234_5678, o_write_register=8, o_reg_write=1.
- Loads with read_data=0x80FF_7F01:
  - byte, offset 1, signed → 0x0000_007F;
  - byte, offset 3, signed → 0xFFFF_FF80;
  - byte, offset 3, unsigned → 0x0000_0080;
  - half, offset 2, signed → 0xFFFF_80FF;
  - half, offset 3 → same as offset 2.
- Link and $0: wb_sel=10, pc_plus_4=0x0040_0008, rd=31 → o_write_data=0x0040_0008. The same with rd=0 → o_reg_write=0.
- Stall/flush: stall 3 cycles → outputs constant. Stall and flush together → o_valid=0, o_reg_write=0 next cycle.
- Counter (macro on):
  - 5 valid captures with 1 stalled and 1 flushed cycle interleaved → count=5;
  - starting from 2^CNT_W−1, one capture → 0;
  - clear concurrent with a capture → 0.
